stage_view_ctrl: RTL
====================

STAGE_VIEW_CTRL -- requirements
Module: stage_view_ctrl

Interface
REQ-001 Parameter NSTAGE, default 8: number of stage LEDs, range 2..16.
REQ-002 Parameter BLINK_DIV, default 25000000: cp cycles per blink half-period, minimum 2.
REQ-003 Parameter FINISH_FLASHES, default 6: blink half-periods of flashing on entry to finishST, range 1..255.
REQ-004 cp  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 state  in  3  controller state: shutDownST=0, beginST=1, setST=2, runST=3, errorST=4, pauseST=5, finishST=6.
REQ-007 stage_en  in  NSTAGE  steady per-stage enable pattern.
REQ-008 active_stage  in  clog2(NSTAGE)  index of the currently running stage.
REQ-009 power_on  in  1  power indicator request.
REQ-010 set_mode  in  1  set indicator request.
REQ-011 in_left, in_middle, in_right  in  6 each  digit codes for the ShowView block.
REQ-012 stage_led  out  NSTAGE  stage LED drive.
REQ-013 power_led, set_led  out  1 each  indicator LEDs.
REQ-014 dig_left, dig_middle, dig_right  out  6 each  digit codes to ShowView.
REQ-015 blink  out  1  current blink phase.

Function
REQ-016 All outputs SHALL be registered, with one cp cycle latency from inputs.
REQ-017 Blink generator: counter 0..BLINK_DIV-1, wrapping to 0 and toggling phase on wrap.
REQ-018 Counter SHALL clear and phase SHALL set to 1 on any cycle where active_stage changes or state enters runST, so a new active stage starts lit.
REQ-019 shutDownST and undefined state 7: stage_led=0, set_led=0, all digits EMPTY (55).
REQ-020 beginST: stage_led all ones, set_led=1, all digits FULL (56).
REQ-021 setST: stage_led=stage_en, set_led=set_mode, digits pass through.
REQ-022 runST: stage_led=stage_en, except bit active_stage, which SHALL equal blink phase; set_led=set_mode; digits pass through.
REQ-023 active_stage >= NSTAGE in runST: no bit blinks and stage_led=stage_en.
REQ-024 pauseST: active bit steady 1; dig_middle=PAUSE (57); dig_left and dig_right SHALL pass through when phase=1 and show EMPTY when phase=0.
REQ-025 errorST: stage_led all zero except active bit, which SHALL toggle every BLINK_DIV/2 cycles (double rate); digits pass through.
REQ-026 finishST entry: flash_cnt SHALL load FINISH_FLASHES; each blink wrap SHALL decrement it.
REQ-027 finishST while flash_cnt>0: stage_led all ones when phase=1 and zero when phase=0; set_led follows phase; digits FULL/EMPTY following phase.
REQ-028 finishST at flash_cnt=0: all ones, set_led=1, digits FULL, held steady.
REQ-029 flash_cnt SHALL clear when leaving finishST; re-entry restarts the flash sequence.
REQ-030 power_led SHALL equal power_on in every state except shutDownST, where it is 0.
REQ-031 blink output SHALL equal phase in all states.

Reset
REQ-032 On reset: counter=0, phase=0, flash_cnt=0, stage_led=0, power_led=0, set_led=0, blink=0, digits EMPTY.
REQ-033 Reset mid-flash or mid-blink SHALL abort the sequence; the first post-reset cycle SHALL use reset values.
REQ-034 The previous-state and previous-active_stage registers SHALL reset to shutDownST and 0.

Structure
REQ-035 Package washer_view_pkg SHALL hold the state encodings and the digit codes EMPTY=55, FULL=56, PAUSE=57.
REQ-036 Blink counter and phase SHALL be a sub-module blink_gen (parameter BLINK_DIV; ports: restart, phase, wrap, half_wrap).

Verification (NSTAGE=8, BLINK_DIV=4, FINISH_FLASHES=3)
REQ-037 reset high 2 cycles, state=3 -> stage_led=0, digits 55/55/55, blink=0.
REQ-038 state=3, stage_en=0x0F, active_stage=2 -> stage_led alternates 0x0F/0x0B every 4 cycles, starting 0x0F.
REQ-039 In runST, active_stage 2->5 mid-half-period -> phase restarts at 1 next cycle; bit5 lit 4 cycles.
REQ-040 state=5, in_middle=7 -> dig_middle=57 steady; active bit steady 1; left/right toggle to 55 every 4 cycles.
REQ-041 Enter state=6 -> stage_led toggles 0xFF/0x00 for 3 half-periods, then holds 0xFF with digits 56.
REQ-042 Reset asserted during finish flashing, then state=6 re-entered -> full 3-flash sequence repeats.

Source files
------------

// File: rtl/washer_view_pkg.sv
// Shared encodings for the washer front-panel view: controller states and
// the ShowView digit codes that the panel drivers substitute for real digits.
package washer_view_pkg;

  typedef enum logic [2:0] {
    SHUTDOWN_ST = 3'd0,
    BEGIN_ST    = 3'd1,
    SET_ST      = 3'd2,
    RUN_ST      = 3'd3,
    ERROR_ST    = 3'd4,
    PAUSE_ST    = 3'd5,
    FINISH_ST   = 3'd6,
    UNDEF_ST    = 3'd7
  } state_e;

  localparam logic [5:0] DIG_EMPTY = 6'd55;
  localparam logic [5:0] DIG_FULL  = 6'd56;
  localparam logic [5:0] DIG_PAUSE = 6'd57;

  // Digit shown in the lit half of a blink, blanked in the dark half.
  function automatic logic [5:0] phase_digit(input logic ph, input logic [5:0] lit_code);
    return ph ? lit_code : DIG_EMPTY;
  endfunction

endpackage

// File: rtl/stage_view_ctrl_blink_gen.sv
// Blink timebase: a half-period counter with a phase bit; restart forces a
// fresh lit half-period, wrap/half_wrap flag the edges where phase changes.
module blink_gen #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic cp,
  input  logic reset,
  input  logic restart,
  output logic phase,
  output logic wrap,
  output logic half_wrap
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BLINK_DIV / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    wrap      = (cnt_q == LAST);
    half_wrap = wrap || (cnt_q == HALF_LAST);
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
    end
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/stage_view_ctrl.sv
// Front-panel view controller: maps controller state, stage enables and digit
// codes onto registered LED and ShowView outputs with blink/flash effects.
module stage_view_ctrl
  import washer_view_pkg::*;
#(
  parameter int NSTAGE         = 8,
  parameter int BLINK_DIV      = 25000000,
  parameter int FINISH_FLASHES = 6
) (
  input  logic                      cp,
  input  logic                      reset,
  input  logic [2:0]                state,
  input  logic [NSTAGE-1:0]         stage_en,
  input  logic [$clog2(NSTAGE)-1:0] active_stage,
  input  logic                      power_on,
  input  logic                      set_mode,
  input  logic [5:0]                in_left,
  input  logic [5:0]                in_middle,
  input  logic [5:0]                in_right,
  output logic [NSTAGE-1:0]         stage_led,
  output logic                      power_led,
  output logic                      set_led,
  output logic [5:0]                dig_left,
  output logic [5:0]                dig_middle,
  output logic [5:0]                dig_right,
  output logic                      blink
);

  localparam int AW = $clog2(NSTAGE);
  localparam logic [7:0] FLASH_INIT = 8'(FINISH_FLASHES);
  localparam logic [NSTAGE-1:0] ONE_HOT0 = {{(NSTAGE-1){1'b0}}, 1'b1};

  state_e            state_s;
  state_e            prev_state_q;
  logic [AW-1:0]     prev_active_q;
  logic              fast_q, fast_d;
  logic [7:0]        flash_q, flash_d;
  logic              restart_s, phase_s, wrap_s, half_wrap_s, wrap_ev_s, phase_next_s;
  logic [NSTAGE-1:0] active_mask_s;

  logic [NSTAGE-1:0] stage_led_q, stage_led_d;
  logic              power_led_q, power_led_d;
  logic              set_led_q, set_led_d;
  logic [5:0]        dig_left_q, dig_left_d;
  logic [5:0]        dig_middle_q, dig_middle_d;
  logic [5:0]        dig_right_q, dig_right_d;
  logic              blink_q;

  assign state_s   = state_e'(state);
  assign restart_s = (active_stage != prev_active_q) ||
                     ((state_s == RUN_ST) && (prev_state_q != RUN_ST));
  assign wrap_ev_s = wrap_s && !restart_s;

  blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .cp        (cp),
    .reset     (reset),
    .restart   (restart_s),
    .phase     (phase_s),
    .wrap      (wrap_s),
    .half_wrap (half_wrap_s)
  );

  // Outputs are built from the phase the blink generator holds after this
  // edge, so a restarted stage appears lit on the very next cycle.
  always_comb begin
    phase_next_s  = restart_s ? 1'b1 : (phase_s ^ wrap_s);
    fast_d        = restart_s ? 1'b1 : (fast_q ^ half_wrap_s);
    active_mask_s = (int'(active_stage) < NSTAGE) ? (ONE_HOT0 << active_stage) : '0;
    if (state_s != FINISH_ST) begin
      flash_d = 8'd0;
    end else if (prev_state_q != FINISH_ST) begin
      flash_d = FLASH_INIT;
    end else if (wrap_ev_s && (flash_q != 8'd0)) begin
      flash_d = flash_q - 8'd1;
    end else begin
      flash_d = flash_q;
    end
  end

  always_comb begin
    stage_led_d  = '0;
    set_led_d    = 1'b0;
    dig_left_d   = DIG_EMPTY;
    dig_middle_d = DIG_EMPTY;
    dig_right_d  = DIG_EMPTY;
    power_led_d  = (state_s == SHUTDOWN_ST) ? 1'b0 : power_on;
    case (state_s)
      BEGIN_ST: begin
        stage_led_d  = '1;
        set_led_d    = 1'b1;
        dig_left_d   = DIG_FULL;
        dig_middle_d = DIG_FULL;
        dig_right_d  = DIG_FULL;
      end
      SET_ST: begin
        stage_led_d  = stage_en;
        set_led_d    = set_mode;
        dig_left_d   = in_left;
        dig_middle_d = in_middle;
        dig_right_d  = in_right;
      end
      RUN_ST: begin
        stage_led_d  = (stage_en & ~active_mask_s) | (phase_next_s ? active_mask_s : '0);
        set_led_d    = set_mode;
        dig_left_d   = in_left;
        dig_middle_d = in_middle;
        dig_right_d  = in_right;
      end
      ERROR_ST: begin
        stage_led_d  = fast_d ? active_mask_s : '0;
        set_led_d    = set_mode;
        dig_left_d   = in_left;
        dig_middle_d = in_middle;
        dig_right_d  = in_right;
      end
      PAUSE_ST: begin
        stage_led_d  = stage_en | active_mask_s;
        set_led_d    = set_mode;
        dig_left_d   = phase_digit(phase_next_s, in_left);
        dig_middle_d = DIG_PAUSE;
        dig_right_d  = phase_digit(phase_next_s, in_right);
      end
      FINISH_ST: begin
        if (flash_d != 8'd0) begin
          stage_led_d  = phase_next_s ? '1 : '0;
          set_led_d    = phase_next_s;
          dig_left_d   = phase_digit(phase_next_s, DIG_FULL);
          dig_middle_d = phase_digit(phase_next_s, DIG_FULL);
          dig_right_d  = phase_digit(phase_next_s, DIG_FULL);
        end else begin
          stage_led_d  = '1;
          set_led_d    = 1'b1;
          dig_left_d   = DIG_FULL;
          dig_middle_d = DIG_FULL;
          dig_right_d  = DIG_FULL;
        end
      end
      default: begin
        stage_led_d  = '0;
        set_led_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      prev_state_q  <= SHUTDOWN_ST;
      prev_active_q <= '0;
      fast_q        <= 1'b0;
      flash_q       <= 8'd0;
      stage_led_q   <= '0;
      power_led_q   <= 1'b0;
      set_led_q     <= 1'b0;
      dig_left_q    <= DIG_EMPTY;
      dig_middle_q  <= DIG_EMPTY;
      dig_right_q   <= DIG_EMPTY;
      blink_q       <= 1'b0;
    end else begin
      prev_state_q  <= state_s;
      prev_active_q <= active_stage;
      fast_q        <= fast_d;
      flash_q       <= flash_d;
      stage_led_q   <= stage_led_d;
      power_led_q   <= power_led_d;
      set_led_q     <= set_led_d;
      dig_left_q    <= dig_left_d;
      dig_middle_q  <= dig_middle_d;
      dig_right_q   <= dig_right_d;
      blink_q       <= phase_next_s;
    end
  end

  assign stage_led  = stage_led_q;
  assign power_led  = power_led_q;
  assign set_led    = set_led_q;
  assign dig_left   = dig_left_q;
  assign dig_middle = dig_middle_q;
  assign dig_right  = dig_right_q;
  assign blink      = blink_q;

endmodule
